// File: rtl/game_stats_if.sv
// Event and statistics bundle between the game logic, the statistics
// engine and the HEX display loader.
interface game_stats_if;
    logic       new_game;
    logic       enemy_kill;
    logic       player_hit;
    logic       fire_req;
    logic       fire_ok;
    logic [7:0] score;
    logic [7:0] high_score;
    logic [7:0] health;
    logic [7:0] heat;
    logic       overheated;
    logic       game_over;
    logic [1:0] state;

    // Game logic / display side: raises event pulses, consumes the stats.
    modport master (
        output new_game, enemy_kill, player_hit, fire_req,
        input  fire_ok, score, high_score, health, heat,
        input  overheated, game_over, state
    );

    // Statistics engine side.
    modport slave (
        input  new_game, enemy_kill, player_hit, fire_req,
        output fire_ok, score, high_score, health, heat,
        output overheated, game_over, state
    );
endinterface

// File: rtl/game_stats.sv
// Gameplay statistics engine: owns the IDLE/PLAY/OVER state machine, the
// cooldown tick divider and every value shown on the HEX displays. All
// outputs come straight from registers because they feed the display
// load inputs directly.
module game_stats #(
    parameter int unsigned TICK_DIV    = 32'd25_000_000,
    parameter logic [7:0]  HEALTH_INIT = 8'hFF,
    parameter logic [7:0]  HIT_DMG     = 8'h10,
    parameter logic [7:0]  HEAT_STEP   = 8'h20
) (
    input  logic          clock,
    input  logic          resetn,
    game_stats_if.slave   bus
);

    localparam int unsigned        DIV_W    = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0]   DIV_LOAD = DIV_W'(TICK_DIV - 32'd1);
    localparam logic [DIV_W-1:0]   DIV_ONE  = DIV_W'(32'd1);
    localparam logic [DIV_W-1:0]   DIV_ZERO = DIV_W'(32'd0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10
    } state_t;

    // Saturating increment, stops at 8'hFF.
    function automatic logic [7:0] sat_inc8(input logic [7:0] a);
        sat_inc8 = (a == 8'hFF) ? 8'hFF : (a + 8'd1);
    endfunction

    // Saturating subtract, stops at 8'h00.
    function automatic logic [7:0] sat_sub8(input logic [7:0] a, input logic [7:0] b);
        sat_sub8 = (a > b) ? (a - b) : 8'h00;
    endfunction

    // Larger of two unsigned bytes.
    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        max8 = (a > b) ? a : b;
    endfunction

    state_t           state_r,  state_s;
    logic [7:0]       score_r,  score_s;
    logic [7:0]       high_r,   high_s;
    logic [7:0]       health_r, health_s;
    logic [7:0]       heat_r,   heat_s;
    logic             ovh_r,    ovh_s;
    logic             fok_r,    fok_s;
    logic             gov_r,    gov_s;
    logic [DIV_W-1:0] div_r,    div_s;

    logic             tick_s;
    logic [8:0]       heat_sum_s;
    logic             accept_s;
    logic             reject_s;
    logic             fatal_s;

    // State and statistics registers; high score survives everything but resetn.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r  <= ST_IDLE;
            score_r  <= 8'h00;
            high_r   <= 8'h00;
            health_r <= 8'h00;
            heat_r   <= 8'h00;
            ovh_r    <= 1'b0;
            fok_r    <= 1'b0;
            gov_r    <= 1'b0;
            div_r    <= DIV_LOAD;
        end else begin
            state_r  <= state_s;
            score_r  <= score_s;
            high_r   <= high_s;
            health_r <= health_s;
            heat_r   <= heat_s;
            ovh_r    <= ovh_s;
            fok_r    <= fok_s;
            gov_r    <= gov_s;
            div_r    <= div_s;
        end
    end

    // Next-state and next-statistics logic; simultaneous events combine here.
    always_comb begin
        state_s    = state_r;
        score_s    = score_r;
        high_s     = high_r;
        health_s   = health_r;
        heat_s     = heat_r;
        ovh_s      = ovh_r;
        fok_s      = 1'b0;
        div_s      = div_r;
        tick_s     = (div_r == DIV_ZERO);
        heat_sum_s = {1'b0, heat_r} + {1'b0, HEAT_STEP};
        accept_s   = 1'b0;
        reject_s   = 1'b0;
        fatal_s    = 1'b0;

        case (state_r)
            ST_IDLE, ST_OVER: begin
                // A new game overrides every other event in the same cycle.
                if (bus.new_game) begin
                    state_s  = ST_PLAY;
                    score_s  = 8'h00;
                    health_s = HEALTH_INIT;
                    heat_s   = 8'h00;
                    ovh_s    = 1'b0;
                    div_s    = DIV_LOAD;
                end else begin
                    state_s  = state_r;
                end
            end
            ST_PLAY: begin
                div_s    = tick_s ? DIV_LOAD : (div_r - DIV_ONE);
                score_s  = bus.enemy_kill ? sat_inc8(score_r) : score_r;
                health_s = bus.player_hit ? sat_sub8(health_r, HIT_DMG) : health_r;
                fatal_s  = bus.player_hit && (health_s == 8'h00);

                // The 9-bit sum lets an exact fit to 8'hFF still be granted.
                if (bus.fire_req && !ovh_r) begin
                    accept_s = (heat_sum_s <= 9'h0FF);
                    reject_s = (heat_sum_s >  9'h0FF);
                end else begin
                    accept_s = 1'b0;
                    reject_s = 1'b0;
                end

                if (accept_s) begin
                    heat_s = tick_s ? sat_sub8(heat_sum_s[7:0], 8'd1) : heat_sum_s[7:0];
                    fok_s  = 1'b1;
                end else if (reject_s) begin
                    heat_s = 8'hFF;
                    ovh_s  = 1'b1;
                end else if (tick_s) begin
                    heat_s = sat_sub8(heat_r, 8'd1);
                    ovh_s  = (heat_s == 8'h00) ? 1'b0 : ovh_r;
                end else begin
                    heat_s = heat_r;
                end

                // A fatal hit ends the game: weapon state freezes where it was,
                // and the score including a same-cycle kill is recorded.
                if (fatal_s) begin
                    state_s = ST_OVER;
                    high_s  = max8(high_r, score_s);
                    heat_s  = heat_r;
                    ovh_s   = ovh_r;
                    fok_s   = 1'b0;
                end else begin
                    state_s = ST_PLAY;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        gov_s = (state_s == ST_OVER);
    end

    assign bus.fire_ok    = fok_r;
    assign bus.score      = score_r;
    assign bus.high_score = high_r;
    assign bus.health     = health_r;
    assign bus.heat       = heat_r;
    assign bus.overheated = ovh_r;
    assign bus.game_over  = gov_r;
    assign bus.state      = state_r;

endmodule

// File: tb/tb_game_stats.sv
// Directed bench for game_stats: each stimulus step pushes the hand-derived
// post-edge output snapshot into a scoreboard; a monitor pops and compares
// on the following falling edge.
module tb_game_stats;

    typedef struct packed {
        logic [7:0] score;
        logic [7:0] high;
        logic [7:0] health;
        logic [7:0] heat;
        logic       ovh;
        logic       fok;
        logic       gov;
        logic [1:0] st;
    } exp_t;

    logic  clock  = 1'b0;
    logic  resetn = 1'b1;
    int    checks = 0;
    int    errors = 0;
    exp_t  e;
    exp_t  sbq[$];
    string tq[$];

    logic [7:0] heat_tab [12] = '{8'h20, 8'h40, 8'h60, 8'h7F, 8'h9F, 8'hBF,
                                  8'hDF, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFE};

    always #5 clock = ~clock;

    game_stats_if gif();

    game_stats #(
        .TICK_DIV   (32'd4),
        .HEALTH_INIT(8'hFF),
        .HIT_DMG    (8'h10),
        .HEAT_STEP  (8'h20)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (gif)
    );

    task automatic compare(input string t, input exp_t x);
        exp_t got;
        got.score  = gif.score;
        got.high   = gif.high_score;
        got.health = gif.health;
        got.heat   = gif.heat;
        got.ovh    = gif.overheated;
        got.fok    = gif.fire_ok;
        got.gov    = gif.game_over;
        got.st     = gif.state;
        checks++;
        if (got !== x) begin
            errors++;
            $display("FAIL %s (got/exp) score %h/%h high %h/%h health %h/%h heat %h/%h ovh %b/%b fok %b/%b gov %b/%b state %b/%b",
                     t, got.score, x.score, got.high, x.high, got.health, x.health,
                     got.heat, x.heat, got.ovh, x.ovh, got.fok, x.fok,
                     got.gov, x.gov, got.st, x.st);
        end
    endtask

    // Monitor: one scoreboard entry per clocked step, checked mid-cycle.
    always @(negedge clock) begin : monitor
        exp_t  x;
        string t;
        if (sbq.size() > 0) begin
            x = sbq.pop_front();
            t = tq.pop_front();
            compare(t, x);
        end
    end

    task automatic step(input logic ng, input logic k, input logic h, input logic f, input string t);
        @(negedge clock);
        gif.new_game   = ng;
        gif.enemy_kill = k;
        gif.player_hit = h;
        gif.fire_req   = f;
        @(posedge clock);
        #1;
        gif.new_game   = 1'b0;
        gif.enemy_kill = 1'b0;
        gif.player_hit = 1'b0;
        gif.fire_req   = 1'b0;
        sbq.push_back(e);
        tq.push_back(t);
    endtask

    task automatic newgame(input logic k, input logic h, input logic f, input string t);
        e.score  = 8'h00;
        e.health = 8'hFF;
        e.heat   = 8'h00;
        e.ovh    = 1'b0;
        e.fok    = 1'b0;
        e.gov    = 1'b0;
        e.st     = 2'b01;
        step(1'b1, k, h, f, t);
    endtask

    task automatic kills(input int n, input string t);
        for (int i = 0; i < n; i++) begin
            e.score = (e.score == 8'hFF) ? 8'hFF : (e.score + 8'd1);
            step(1'b0, 1'b1, 1'b0, 1'b0, t);
        end
    endtask

    task automatic hits15();
        for (int i = 1; i <= 15; i++) begin
            e.health = e.health - 8'h10;
            step(1'b0, 1'b0, 1'b1, 1'b0, "hit");
        end
    endtask

    task automatic die(input logic [7:0] exp_high, input string t);
        hits15();
        e.health = 8'h00;
        e.st     = 2'b10;
        e.gov    = 1'b1;
        e.high   = exp_high;
        step(1'b0, 1'b0, 1'b1, 1'b0, t);
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic async_reset(input string t);
        @(negedge clock);
        #2;
        resetn = 1'b0;
        e = '0;
        #1;
        compare(t, e);
        repeat (2) @(posedge clock);
        #1;
        compare({t, "_held"}, e);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        gif.new_game   = 1'b0;
        gif.enemy_kill = 1'b0;
        gif.player_hit = 1'b0;
        gif.fire_req   = 1'b0;
        e = '0;
        #1 resetn = 1'b0;
        #11;
        compare("reset", e);
        @(negedge clock);
        resetn = 1'b1;

        // Events in IDLE are ignored.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, "idle_kill");

        // Game A: reach 0x30 and die.
        newgame(1'b0, 1'b0, 1'b0, "ng_idle");
        kills(3, "kill");
        step(1'b1, 1'b0, 1'b0, 1'b0, "ng_play_ignored");
        kills(45, "kill_to_30");
        die(8'h30, "fatal_a");
        step(1'b0, 1'b1, 1'b1, 1'b1, "over_hold");

        // Game B: new game with a same-cycle kill, then kill plus fatal hit at 0x41.
        newgame(1'b1, 1'b0, 1'b0, "ng_over");
        kills(65, "kill_to_41");
        hits15();
        e.score  = 8'h42;
        e.health = 8'h00;
        e.high   = 8'h42;
        e.st     = 2'b10;
        e.gov    = 1'b1;
        step(1'b0, 1'b1, 1'b1, 1'b0, "kill_and_fatal");

        // Game C: 300 kills saturate the score.
        newgame(1'b0, 1'b0, 1'b0, "ng_c");
        kills(300, "kill_sat");
        die(8'hFF, "fatal_c");

        // Game D: lower score leaves the high score alone.
        newgame(1'b0, 1'b0, 1'b0, "ng_d");
        kills(2, "kill_d");
        die(8'hFF, "high_keep");

        // Game E: fire every cycle with TICK_DIV=4; ticks on edges 4, 8, 12, ...
        newgame(1'b0, 1'b0, 1'b0, "ng_fire");
        for (int n = 1; n <= 12; n++) begin
            e.heat = heat_tab[n-1];
            e.fok  = (n <= 8);
            e.ovh  = (n >= 9);
            step(1'b0, 1'b0, 1'b0, 1'b1, "fire");
        end
        for (int n = 13; n <= 1028; n++) begin
            if ((n % 4) == 0) e.heat = e.heat - 8'd1;
            e.ovh = (e.heat != 8'h00);
            e.fok = 1'b0;
            step(1'b0, 1'b0, 1'b0, 1'b1, "cooldown");
        end
        e.heat = 8'h20;
        e.fok  = 1'b1;
        e.ovh  = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b1, "refire");
        e.fok  = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, "fok_drop");

        // Clear high score, build high 0x20 and heat 0x40, then reset mid-game.
        async_reset("reset_clear");
        newgame(1'b0, 1'b0, 1'b0, "ng_f");
        kills(32, "kill_to_20");
        die(8'h20, "fatal_f");
        newgame(1'b0, 1'b0, 1'b0, "ng_g");
        e.heat = 8'h20;
        e.fok  = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1, "fire_g1");
        e.heat = 8'h40;
        step(1'b0, 1'b0, 1'b0, 1'b1, "fire_g2");
        async_reset("async_reset");
        step(1'b0, 1'b0, 1'b0, 1'b0, "post_reset");
        newgame(1'b0, 1'b0, 1'b0, "resume");

        for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge clock);
        #1;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d required 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
